// File: rtl/noc_pkg.sv
// Shared types for the NoC receive endpoint: flit type encoding,
// receive framing states and the default flit width.
package noc_pkg;

    localparam int NOC_DATA_WIDTH = 34;
    // Type field spans [DATA_WIDTH-1 : DATA_WIDTH-1-FLIT_TYPE_MSB].
    localparam int FLIT_TYPE_MSB  = 1;

    typedef enum logic [1:0] {
        FLIT_BODY   = 2'b00,
        FLIT_HEAD   = 2'b01,
        FLIT_TAIL   = 2'b10,
        FLIT_SINGLE = 2'b11
    } flit_type_e;

    typedef enum logic {
        RX_IDLE = 1'b0,
        RX_OPEN = 1'b1
    } rx_state_e;

endpackage

// File: rtl/noc_sync_fifo.sv
// Circular receive buffer with an extra pointer bit for full/empty
// and a registered head entry.
module noc_sync_fifo
    import noc_pkg::*;
#(
    parameter int DATA_WIDTH = NOC_DATA_WIDTH,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  pop,
    output logic                  full,
    output logic                  empty,
    output logic [DATA_WIDTH-1:0] head
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] head_q;
    logic [AW:0]           wr_ptr;
    logic [AW:0]           rd_ptr;
    logic [AW:0]           rd_next;
    logic                  bypass;

    assign rd_next = pop ? rd_ptr + PTR_ONE : rd_ptr;
    assign bypass  = push && (wr_ptr[AW-1:0] == rd_next[AW-1:0]);

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head  = head_q;

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= wdata;
        end
    end

    // Head tracks the entry at the post-update read pointer, taking
    // the incoming word when it lands exactly there.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            head_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            rd_ptr <= rd_next;
            if (push || pop) begin
                head_q <= bypass ? wdata : mem[rd_next[AW-1:0]];
            end
        end
    end

endmodule

// File: rtl/noc_sync_receiver.sv
// Clocked endpoint of the two-phase bundled-data link: synchronizes the
// request, buffers flits, acknowledges them and checks packet framing.
module noc_sync_receiver
    import noc_pkg::*;
#(
    parameter int DATA_WIDTH  = NOC_DATA_WIDTH,
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  req_up_i,
    input  logic [DATA_WIDTH-1:0] data_up_i,
    output logic                  ack_up_o,
    output logic [DATA_WIDTH-1:0] flit_o,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic                  pkt_active_o,
    output logic                  tail_done_o,
    output logic                  frame_err_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   req_sync;
    logic                   ack_q;
    logic                   pending;
    logic                   accept;
    logic                   pop;
    logic                   full;
    logic                   empty;
    flit_type_e             ftype;
    rx_state_e              state_q;
    rx_state_e              state_n;
    logic                   tail_q;
    logic                   tail_n;
    logic                   err_q;
    logic                   err_n;

    assign req_sync = sync_q[SYNC_STAGES-1];
    // The acknowledge level doubles as the expected request phase.
    assign pending  = (req_sync != ack_q);
    assign pop      = !empty && ready_i;
    assign accept   = pending && (!full || pop);
    assign ftype    = flit_type_e'(data_up_i[DATA_WIDTH-1 -: FLIT_TYPE_MSB+1]);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync_q <= '0;
            ack_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], req_up_i};
            if (accept) begin
                ack_q <= ~ack_q;
            end
        end
    end

    noc_sync_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .push   (accept),
        .wdata  (data_up_i),
        .pop    (pop),
        .full   (full),
        .empty  (empty),
        .head   (flit_o)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= RX_IDLE;
            tail_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_n;
            tail_q  <= tail_n;
            err_q   <= err_n;
        end
    end

    always_comb begin
        state_n = state_q;
        tail_n  = 1'b0;
        err_n   = 1'b0;
        if (accept) begin
            unique case (ftype)
                FLIT_HEAD: begin
                    err_n   = (state_q == RX_OPEN);
                    state_n = RX_OPEN;
                end
                FLIT_SINGLE: begin
                    err_n   = (state_q == RX_OPEN);
                    tail_n  = 1'b1;
                    state_n = RX_IDLE;
                end
                FLIT_TAIL: begin
                    err_n   = (state_q == RX_IDLE);
                    tail_n  = (state_q == RX_OPEN);
                    state_n = RX_IDLE;
                end
                FLIT_BODY: begin
                    err_n   = (state_q == RX_IDLE);
                end
                default: begin
                    state_n = state_q;
                end
            endcase
        end
    end

    assign ack_up_o     = ack_q;
    assign valid_o      = !empty;
    assign pkt_active_o = (state_q == RX_OPEN);
    assign tail_done_o  = tail_q;
    assign frame_err_o  = err_q;

endmodule

// File: doc/noc_sync_receiver.md
Name: noc_sync_receiver

Overview:
- Clocked destination-side endpoint of the asynchronous MouseTrap link.
- Terminates the two-phase (transition-signalling) bundled-data handshake driven by a router output port's request generator: synchronizes `req_up_i`, captures the flit, toggles `ack_up_o`.
- Buffers flits in a small FIFO and presents them to the core through a valid/ready interface.
- Tracks packet framing (head/tail) and flags framing errors.

Parameters:
- DATA_WIDTH, 34: flit width; bits [DATA_WIDTH-1:DATA_WIDTH-2] carry the flit type, the remainder is payload.
- FIFO_DEPTH, 4: receive buffer entries; power of two, ≥2.
- SYNC_STAGES, 2: flip-flops in the `req_up_i` synchronizer, ≥2.

Ports:
- clk_i  input  1  core clock.
- rst_ni  input  1  reset, synchronous, active-low.
- req_up_i  input  1  two-phase request from the router output port; each transition announces one flit.
- data_up_i  input  DATA_WIDTH  bundled flit data; stable from a `req_up_i` transition until the matching `ack_up_o` transition.
- ack_up_o  output  1  two-phase acknowledge; toggles once per accepted flit.
- flit_o  output  DATA_WIDTH  head-of-FIFO flit.
- valid_o  output  1  `flit_o` is valid.
- ready_i  input  1  core accepts `flit_o`; a pop occurs when `valid_o && ready_i`.
- pkt_active_o  output  1  a packet is open (head received, tail not yet received).
- tail_done_o  output  1  one-cycle pulse when a tail or single-flit packet is written into the FIFO.
- frame_err_o  output  1  one-cycle pulse on a framing violation.

Behaviour:
- Reset (rst_ni=0 at a clk_i edge):
  - `ack_up_o`=0; synchronizer flops=0; FIFO empty; `valid_o`=0; `flit_o`=0.
  - `pkt_active_o`=0; `tail_done_o`=0; `frame_err_o`=0; framing state IDLE.
- Reset mid-operation:
  - Any in-flight flit is discarded and FIFO contents are lost.
  - The link sender is reset in the same domain event, so `req_up_i`=0 after reset; no event is generated while `req_up_i` equals `ack_up_o`.
- Event detection:
  - `req_sync` is the last synchronizer stage.
  - A pending event exists when `req_sync != ack_up_o`.
  - The phase is tracked by `ack_up_o` itself; no separate phase register.
- Accept:
  - Condition: event pending and (FIFO count < FIFO_DEPTH, or a pop occurs in the same cycle).
  - Action: write `data_up_i` into the FIFO and toggle `ack_up_o`, both registered at the same edge.
  - The cycle after an accept, `req_sync == ack_up_o`, so each transition is captured exactly once.
- Backpressure: FIFO full with no concurrent pop → hold; `ack_up_o` does not toggle and the sender stalls. The event stays pending and is accepted on the first cycle a slot frees.
- Latency: from the `req_up_i` toggle, the flit is visible on `flit_o` with `valid_o`=1 after SYNC_STAGES+1 rising edges (FIFO non-empty, no stall). `ack_up_o` toggles on the same edge the flit is written.
- FIFO:
  - Circular buffer with read/write pointers of log2(FIFO_DEPTH)+1 bits; the extra MSB distinguishes full from empty; pointers wrap modulo 2·FIFO_DEPTH.
  - `flit_o` is the registered head entry; `valid_o` = not empty.
  - Simultaneous push and pop: count unchanged.
  - Push into empty with no pop: `valid_o` rises the next cycle.
- Flit types (2 MSBs): BODY=2'b00, HEAD=2'b01, TAIL=2'b10, SINGLE=2'b11.
- Framing FSM, advanced only on accepted flits:

  | State | Flit | Next state | Pulse |
  |---|---|---|---|
  | IDLE | HEAD | OPEN | — |
  | IDLE | SINGLE | IDLE | `tail_done_o` |
  | IDLE | BODY or TAIL | IDLE | `frame_err_o` |
  | OPEN | BODY | OPEN | — |
  | OPEN | TAIL | IDLE | `tail_done_o` |
  | OPEN | HEAD or SINGLE | OPEN, treated as a new packet start | `frame_err_o`; SINGLE also pulses `tail_done_o` and goes to IDLE |

  - `pkt_active_o` = (state == OPEN).
  - Erroneous flits are still stored and acknowledged; the link is never blocked by framing errors.
- Outputs are registered; no combinational path from `req_up_i` to `ack_up_o`.

Decomposition:
- Shared package `noc_pkg`:
  - typedef `flit_type_e` (BODY/HEAD/TAIL/SINGLE) and the FLIT_TYPE_MSB offset.
  - typedef `rx_state_e` (IDLE/OPEN).
  - default DATA_WIDTH constant.
- One sub-module: `noc_sync_fifo` (parameterized DATA_WIDTH/FIFO_DEPTH, push/pop/full/empty, registered head output).
- The synchronizer is an inline flop chain.

Test Plan:
1. Reset, then toggle `req_up_i` 0→1 with data=HEAD|0x1234, ready_i=1 → `ack_up_o` 0→1 after 3 edges; `valid_o`=1 with `flit_o`=0x1_00001234 on edge 3; `pkt_active_o`=1.
2. ready_i=0; send 5 flits (HEAD, BODY×3, TAIL) back-to-back on the handshake → 4 acks issued; 5th req pending with `ack_up_o` unchanged. Raise ready_i → 5th accepted within 1 cycle of the first pop; all 5 popped in order; `tail_done_o` pulses once.
3. Continuous traffic of 12 flits with ready_i=1 → pointers wrap 1.5 times; output order matches input; no duplicate or lost flit; the ack toggle count equals 12.
4. BODY while IDLE → `frame_err_o` 1-cycle pulse; flit delivered. HEAD while OPEN → `frame_err_o` pulse; `pkt_active_o` stays 1.
5. SINGLE flit → `tail_done_o` pulse; `pkt_active_o` stays 0.
6. Assert rst_ni=0 with 3 flits buffered and a req pending, sender reset too → after release `valid_o`=0 and `ack_up_o`=0; the next req transition is delivered normally.
